// File: rtl/sr_seq_pkg.sv
// Shared types and constants for the SR latch sequencer: FSM states, error codes,
// and a helper to size the shared phase counter.
package sr_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        CHECK,
        GAP
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_IDX   = 2'b01;
    localparam logic [1:0] ERR_WRONG = 2'b10;
    localparam logic [1:0] ERR_RAIL  = 2'b11;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sr_seq_timer.sv
// Loadable down-counter shared by the PULSE, CHECK and GAP phases; expired is high
// while the count sits at 1, and the count holds there rather than wrapping.
module sr_seq_timer #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          expired
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt > CW'(1)) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign expired = (cnt == CW'(1));

endmodule

// File: rtl/sr_latch_sequencer.sv
// Sequences one set/clear pulse onto a NOR SR latch bank, verifies the dual-rail readback, then idles a gap;
// accept-to-ready is 1+PULSE_CYC+k+GAP_CYC cycles, req_ready only in IDLE. Option: SR_SEQ_SKIP_REDUNDANT_EN.
module sr_latch_sequencer
    import sr_seq_pkg::*;
#(
    parameter int N_LATCH    = 4,
    parameter int PULSE_CYC  = 4,
    parameter int SETTLE_MAX = 8,
    parameter int GAP_CYC    = 2,
    parameter int IW         = (N_LATCH > 1) ? $clog2(N_LATCH) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [IW-1:0]      req_idx,
    input  logic               req_val,
    output logic [N_LATCH-1:0] s_out,
    output logic [N_LATCH-1:0] r_out,
    input  logic [N_LATCH-1:0] q_in,
    input  logic [N_LATCH-1:0] qn_in,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [1:0]         err_code
);

    localparam int CW = $clog2(max3(PULSE_CYC, SETTLE_MAX, GAP_CYC) + 1);
    localparam logic [CW-1:0] PULSE_LD  = CW'(PULSE_CYC);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_MAX);
    localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC);

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          val_q, val_d;
    logic          done_d, err_d;
    logic [1:0]    code_d;
    logic          tmr_load, tmr_exp;
    logic [CW-1:0] tmr_val;
    logic          op_end;
    logic          q_sel, qn_sel;
    logic          idx_ok;
    logic          skip;

    sr_seq_timer #(.CW(CW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    assign idx_ok    = (int'(req_idx) < N_LATCH);
    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    always_comb begin
        q_sel  = 1'b0;
        qn_sel = 1'b0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (int'(idx_q) == i) begin
                q_sel  = q_in[i];
                qn_sel = qn_in[i];
            end
        end
    end

`ifdef SR_SEQ_SKIP_REDUNDANT_EN
    logic q_req, qn_req;

    always_comb begin
        q_req  = 1'b0;
        qn_req = 1'b0;
        for (int i = 0; i < N_LATCH; i++) begin
            if (int'(req_idx) == i) begin
                q_req  = q_in[i];
                qn_req = qn_in[i];
            end
        end
    end

    assign skip = (q_req == req_val) && (qn_req == ~req_val);
`else
    assign skip = 1'b0;
`endif

    // Only the selected latch is ever driven, and only one of its rails.
    always_comb begin
        s_out = '0;
        r_out = '0;
        if (state_q == PULSE) begin
            for (int i = 0; i < N_LATCH; i++) begin
                if (int'(idx_q) == i) begin
                    s_out[i] = val_q;
                    r_out[i] = ~val_q;
                end
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        val_d    = val_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        code_d   = ERR_NONE;
        tmr_load = 1'b0;
        tmr_val  = '0;
        op_end   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (!idx_ok) begin
                        err_d  = 1'b1;
                        code_d = ERR_IDX;
                    end else begin
                        idx_d = req_idx;
                        val_d = req_val;
                        if (skip) begin
                            done_d = 1'b1;
                            op_end = 1'b1;
                        end else begin
                            state_d  = PULSE;
                            tmr_load = 1'b1;
                            tmr_val  = PULSE_LD;
                        end
                    end
                end
            end
            PULSE: begin
                if (tmr_exp) begin
                    state_d  = CHECK;
                    tmr_load = 1'b1;
                    tmr_val  = SETTLE_LD;
                end
            end
            CHECK: begin
                if ((q_sel == val_q) && (qn_sel == ~val_q)) begin
                    done_d = 1'b1;
                    op_end = 1'b1;
                end else if (tmr_exp) begin
                    err_d  = 1'b1;
                    op_end = 1'b1;
                    // An unknown rail comparison falls through to the illegal-rails code.
                    if (q_sel != qn_sel) begin
                        code_d = ERR_WRONG;
                    end else begin
                        code_d = ERR_RAIL;
                    end
                end
            end
            GAP: begin
                if (tmr_exp) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (op_end) begin
            if (GAP_CYC > 0) begin
                state_d  = GAP;
                tmr_load = 1'b1;
                tmr_val  = GAP_LD;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            val_q    <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            val_q    <= val_d;
            done     <= done_d;
            err      <= err_d;
            err_code <= code_d;
        end
    end

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Self-checking bench for sr_latch_sequencer: vector table plus scoreboard, with a
// behavioural latch-bank model and a hand-written mid-operation reset sequence.
module tb_sr_latch_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_idx;
    logic       req_val;
    logic [3:0] s_out, r_out, q_in, qn_in;
    logic       busy, done, err;
    logic [1:0] err_code;

    sr_latch_sequencer #(
        .N_LATCH    (4),
        .PULSE_CYC  (4),
        .SETTLE_MAX (8),
        .GAP_CYC    (2),
        .IW         (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_val   (req_val),
        .s_out     (s_out),
        .r_out     (r_out),
        .q_in      (q_in),
        .qn_in     (qn_in),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    // Latch bank model: mode 0 settles 2 cycles after the drive falls,
    // mode 1 leaves latch 0 stuck, mode 2 forces both rails low.
    int         mdl_mode;
    logic [3:0] mdl_init;
    logic       mdl_load;
    logic [3:0] q_m, qn_m, pend, tgt;
    int         dly [4];

    always @(negedge clk) begin
        if (mdl_load) begin
            q_m  <= mdl_init;
            qn_m <= ~mdl_init;
            pend <= '0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (!(mdl_mode == 1 && i == 0)) begin
                    if (s_out[i] || r_out[i]) begin
                        pend[i] <= 1'b1;
                        tgt[i]  <= s_out[i];
                        dly[i]  <= 2;
                    end else if (pend[i]) begin
                        if (dly[i] == 1) begin
                            q_m[i]  <= tgt[i];
                            qn_m[i] <= ~tgt[i];
                            pend[i] <= 1'b0;
                        end else begin
                            dly[i] <= dly[i] - 1;
                        end
                    end
                end
            end
        end
    end

    assign q_in  = (mdl_mode == 2) ? 4'b0000 : q_m;
    assign qn_in = (mdl_mode == 2) ? 4'b0000 : qn_m;

    typedef struct {
        logic [2:0] idx;
        logic       val;
        int         mode;
        logic [3:0] init;
        logic [3:0] flags;   // {done, err, err_code}
        int         pulse;
        int         evt;
        int         rdy;
    } vec_t;

    typedef struct {
        logic [3:0] flags;
        int         evt;
    } exp_t;

    vec_t vecs [7];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] idx, input logic val, input int mode,
                                input logic [3:0] init, input logic [3:0] flags,
                                input int pulse, input int evt, input int rdy);
        vec_t v;
        v.idx = idx; v.val = val; v.mode = mode; v.init = init;
        v.flags = flags; v.pulse = pulse; v.evt = evt; v.rdy = rdy;
        return v;
    endfunction

    task automatic run_vec(input vec_t v);
        logic [3:0] one, exp_s, exp_r;
        exp_t       e;
        int         pcnt, bcnt, bad, rdy_c;
        one   = 4'b0001;
        exp_s = v.val ? (one << v.idx) : 4'b0000;
        exp_r = v.val ? 4'b0000 : (one << v.idx);
        pcnt = 0; bcnt = 0; bad = 0; rdy_c = -1;

        @(posedge clk); #1;
        mdl_mode = v.mode;
        mdl_init = v.init;
        mdl_load = 1'b1;
        @(posedge clk); #1;
        mdl_load = 1'b0;
        check("ready_before_req", int'(req_ready), 1);
        req_valid = 1'b1;
        req_idx   = v.idx;
        req_val   = v.val;
        @(posedge clk); #1;
        e.flags = v.flags;
        e.evt   = v.evt;
        sb.push_back(e);
        req_valid = 1'b0;
        req_idx   = ~v.idx;   // must be ignored while busy
        req_val   = ~v.val;

        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (s_out != 4'b0000 || r_out != 4'b0000) begin
                if (s_out == exp_s && r_out == exp_r) pcnt++;
                else bad++;
            end
            if (busy) bcnt++;
            if (done || err) begin
                check("sb_pending", (sb.size() > 0) ? 1 : 0, 1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("sb_flags", int'({done, err, err_code}), int'(e.flags));
                    check("sb_latency", c, e.evt);
                end
            end
            if (req_ready) begin
                rdy_c = c;
                break;
            end
            @(posedge clk); #1;
        end

        check("ready_cycle", rdy_c, v.rdy);
        check("pulse_cycles", pcnt, v.pulse);
        check("busy_cycles", bcnt, v.rdy - 1);
        check("illegal_drive", bad, 0);
        check("sb_drained", sb.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ev;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_idx   = 3'd0;
        req_val   = 1'b0;
        mdl_mode  = 0;
        mdl_init  = 4'b0000;
        mdl_load  = 1'b1;

        vecs[0] = mk(3'd2, 1'b1, 0, 4'b0000, 4'b1000, 4, 7, 9);
        vecs[1] = mk(3'd0, 1'b0, 1, 4'b0001, 4'b0110, 4, 13, 15);
        vecs[2] = mk(3'd1, 1'b1, 2, 4'b0000, 4'b0111, 4, 13, 15);
        vecs[3] = mk(3'd5, 1'b1, 0, 4'b0000, 4'b0101, 0, 1, 1);
`ifdef SR_SEQ_SKIP_REDUNDANT_EN
        vecs[4] = mk(3'd3, 1'b1, 0, 4'b1000, 4'b1000, 0, 1, 3);
`else
        vecs[4] = mk(3'd3, 1'b1, 0, 4'b1000, 4'b1000, 4, 6, 8);
`endif
        vecs[5] = mk(3'd3, 1'b0, 0, 4'b1000, 4'b1000, 4, 7, 9);
        vecs[6] = mk(3'd0, 1'b1, 0, 4'b0000, 4'b1000, 4, 7, 9);

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_s_out", int'(s_out), 0);
        check("rst_r_out", int'(r_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done_err", int'({done, err}), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_req_ready", int'(req_ready), 1);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during the second PULSE cycle of a set on latch 1.
        @(posedge clk); #1;
        mdl_mode = 0;
        mdl_init = 4'b0000;
        mdl_load = 1'b1;
        @(posedge clk); #1;
        mdl_load  = 1'b0;
        req_valid = 1'b1;
        req_idx   = 3'd1;
        req_val   = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("midrst_pulse_c1", int'(s_out), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("midrst_pulse_c2", int'(s_out), 2);
        @(posedge clk); #1;
        check("midrst_s_out", int'(s_out), 0);
        check("midrst_r_out", int'(r_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_req_ready", int'(req_ready), 1);
        reset = 1'b0;
        ev = 0;
        repeat (16) begin
            @(negedge clk);
            if (done || err || s_out != 4'b0000 || r_out != 4'b0000) ev++;
        end
        check("midrst_no_activity", ev, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
